im2col_window_gen: RTL and testbench
====================================

IM2COL_WINDOW_GEN -- requirements
Module: im2col_window_gen

Interface
REQ-001 The block SHALL take parameter IP_DATA_WIDTH, default yolo_params_pkg::IP_DATA_WIDTH, meaning the input pixel width.
REQ-002 The block SHALL take parameter FILTER_SIZE, default yolo_params_pkg::FILTER_SIZE, meaning the window edge (F).
REQ-003 The block SHALL take parameter OFMAP_SIZE, default yolo_params_pkg::OFMAP_SIZE, meaning the output map edge (O).
REQ-004 The block SHALL take localparam IFMAP_SIZE = OFMAP_SIZE+FILTER_SIZE-1, meaning the input map edge (I); stride 1, no padding.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port in_pixel, input, IP_DATA_WIDTH bits: ifmap pixel, raster order (row-major, row 0 first).
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_pixel valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block accepts in_pixel.
REQ-010 The block SHALL have port out_window, output, [FILTER_SIZE*FILTER_SIZE-1:0] array of 2*IP_DATA_WIDTH bits: one conv_mac matrix row; element k = window row k/F, column k%F, zero-extended.
REQ-011 The block SHALL have port out_row, output, $clog2(OFMAP_SIZE) bits: output row oy of the window.
REQ-012 The block SHALL have port out_col, output, $clog2(OFMAP_SIZE) bits: output column ox of the window.
REQ-013 The block SHALL have port out_last, output, 1 bit: window is (O-1,O-1), last of frame.
REQ-014 The block SHALL have port out_valid, output, 1 bit: window outputs valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream accepts window.

Function
REQ-016 A pixel SHALL transfer when in_valid && in_ready at a clock edge; a window SHALL transfer when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational); no other source of backpressure.
REQ-018 The block SHALL keep column counter x and row counter y (0..I-1) of the next expected pixel; x SHALL increment per accepted pixel, wrap I-1->0 and increment y; y SHALL wrap I-1->0 after pixel (I-1,I-1), starting a new frame with no idle cycle.
REQ-019 The block SHALL hold F-1 line buffers of I pixels each plus an FxF shift-register window; every accepted pixel SHALL shift the window left by one column and push the new column from line buffers (oldest row top) plus the new pixel (bottom).
REQ-020 FSM states SHALL be FILL (y < F-1), STREAM (y >= F-1); FILL->STREAM on accepting pixel (F-2,I-1); STREAM->FILL on accepting pixel (I-1,I-1).
REQ-021 In STREAM, accepting pixel (y,x) with x >= F-1 SHALL produce the window oy=y-F+1, ox=x-F+1, presented with out_valid=1 on the following cycle (latency 1).
REQ-022 Windows SHALL never span a row boundary; pixels with x < F-1 SHALL update state but produce no window.
REQ-023 out_window/out_row/out_col/out_last SHALL hold stable while out_valid && !out_ready.
REQ-024 out_valid SHALL clear after a window transfer unless the same-cycle accepted pixel produces a new window, in which case it SHALL stay 1 with new contents (back-to-back, 1 window/cycle).
REQ-025 Exactly O*O windows per frame, in raster order of (oy,ox); out_last=1 only on (O-1,O-1).
REQ-026 in_valid=0 cycles SHALL not alter any state.

Reset
REQ-027 On rst_n=0, asynchronously: out_valid=0, out_last=0, out_row=0, out_col=0, out_window all zero, x=y=0, FSM=FILL; line buffer contents need not be cleared.
REQ-028 in_ready SHALL be 1 during and after reset (follows REQ-017).
REQ-029 Reset mid-frame SHALL discard the partial frame; the first pixel after release SHALL be treated as (0,0).

Verification (F=3, O=4, I=6, IP_DATA_WIDTH=8, pixel value = raster index 0..35)
REQ-030 Stream frame with out_ready=1, in_valid=1 continuous -> first out_valid the cycle after pixel 14 accepted; window (0,0) = {0,1,2,6,7,8,12,13,14}; 16 windows total.
REQ-031 Same stream -> window (3,3) = {21,22,23,27,28,29,33,34,35}, out_row=3, out_col=3, out_last=1; no window after pixels 18,19 (x<2).
REQ-032 Hold out_ready=0 for 5 cycles at window (1,2) -> in_ready=0, outputs stable {8,9,10,14,15,16,20,21,22}; no pixel lost; all 16 windows delivered.
REQ-033 Two frames back-to-back (second frame values +100) -> second-frame window (0,0) = {100,101,102,106,107,108,112,113,114}; out_last once per frame.
REQ-034 Random in_valid/out_ready gaps -> window sequence identical to REQ-030 reference model.
REQ-035 Assert rst_n=0 after pixel 20, then restream full frame -> outputs zero during reset, then exactly REQ-030 results.

Source files
------------

// File: rtl/yolo_params_pkg.sv
// yolo_params_pkg: shared default dimensions for the YOLO accelerator datapath
package yolo_params_pkg;
   localparam int IP_DATA_WIDTH = 8;
   localparam int FILTER_SIZE   = 3;
   localparam int OFMAP_SIZE    = 4;
endpackage

// File: rtl/im2col_window_gen.sv
// im2col_window_gen: turns a raster ifmap pixel stream into FxF im2col windows (stride 1, no padding)
module im2col_window_gen #(
   parameter int IP_DATA_WIDTH = yolo_params_pkg::IP_DATA_WIDTH,
   parameter int FILTER_SIZE   = yolo_params_pkg::FILTER_SIZE,
   parameter int OFMAP_SIZE    = yolo_params_pkg::OFMAP_SIZE
) (
   input  logic                                                         clk,
   input  logic                                                         rst_n,
   input  logic [IP_DATA_WIDTH-1:0]                                     in_pixel,
   input  logic                                                         in_valid,
   output logic                                                         in_ready,
   output logic [FILTER_SIZE*FILTER_SIZE-1:0][2*IP_DATA_WIDTH-1:0]     out_window,
   output logic [$clog2(OFMAP_SIZE)-1:0]                                out_row,
   output logic [$clog2(OFMAP_SIZE)-1:0]                                out_col,
   output logic                                                         out_last,
   output logic                                                         out_valid,
   input  logic                                                         out_ready
);
   localparam int IFMAP_SIZE = OFMAP_SIZE + FILTER_SIZE - 1;
   localparam int F  = FILTER_SIZE;
   localparam int W  = IP_DATA_WIDTH;
   localparam int K  = F * F;
   localparam int XW = $clog2(IFMAP_SIZE);
   localparam int OW = $clog2(OFMAP_SIZE);
   localparam logic [XW-1:0] X_LAST = XW'(IFMAP_SIZE - 1);
   localparam logic [XW-1:0] X_F1   = XW'(F - 1);
   localparam logic [XW-1:0] Y_F2   = XW'(F - 2);
   localparam logic [OW-1:0] O_LAST = OW'(OFMAP_SIZE - 1);
   localparam logic [0:0] FILL   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [XW-1:0]         x_q, x_d, y_q, y_d;
   logic [W-1:0]          lb_q [F-1][IFMAP_SIZE];
   logic [W-1:0]          win_q [F][F];
   logic [W-1:0]          win_d [F][F];
   logic [W-1:0]          col [F];
   logic [K-1:0][2*W-1:0] out_window_q, out_window_d;
   logic [OW-1:0]         out_row_q, out_col_q, oy, ox;
   logic                  out_last_q, out_valid_q;
   logic                  accept, emit, x_wrap, frame_end;

   assign in_ready   = !out_valid_q || out_ready;
   assign accept     = in_valid && in_ready;
   assign x_wrap     = x_q == X_LAST;
   assign frame_end  = x_wrap && y_q == X_LAST;
   assign emit       = accept && state_q == STREAM && x_q >= X_F1;
   assign oy         = OW'(y_q - X_F1);
   assign ox         = OW'(x_q - X_F1);
   assign x_d        = accept ? (x_wrap ? '0 : x_q + XW'(1)) : x_q;
   assign y_d        = accept && x_wrap ? (frame_end ? '0 : y_q + XW'(1)) : y_q;
   assign state_d    = accept && x_wrap && y_q == Y_F2 ? STREAM : accept && frame_end ? FILL : state_q;
   assign out_window = out_window_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;
   assign out_last   = out_last_q;
   assign out_valid  = out_valid_q;

   // next window: shift left one column, new column = line buffers (oldest row on top) + incoming pixel
   always_comb begin
      for (int r = 0; r < F - 1; r++) col[r] = lb_q[r][x_q];
      col[F-1] = in_pixel;
      for (int r = 0; r < F; r++) begin
         for (int c = 0; c < F - 1; c++) win_d[r][c] = win_q[r][c+1];
         win_d[r][F-1] = col[r];
      end
      for (int k = 0; k < K; k++) out_window_d[k] = {{W{1'b0}}, win_d[k/F][k%F]};
   end

   // line buffers: each accepted pixel moves its column up one buffer and lands in the bottom one
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int j = 0; j < F - 2; j++) lb_q[j][x_q] <= lb_q[j+1][x_q];
         lb_q[F-2][x_q] <= in_pixel;
      end
   end

   // window shift register advances on every accepted pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) win_q <= '{default: '0};
      else if (accept) win_q <= win_d;
   end

   // raster position counters and FILL/STREAM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // output register: load on a produced window, hold while stalled, drop valid after transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_window_q <= '0;
      end else if (emit) begin
         out_valid_q  <= 1'b1;
         out_last_q   <= oy == O_LAST && ox == O_LAST;
         out_row_q    <= oy;
         out_col_q    <= ox;
         out_window_q <= out_window_d;
      end else if (out_ready) begin
         out_valid_q  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_im2col_window_gen.sv
// tb_im2col_window_gen: directed tests for im2col_window_gen with F=3, O=4, I=6
module tb_im2col_window_gen;
   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [7:0]       in_pixel = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [8:0][15:0] out_window;
   logic [1:0]       out_row, out_col;
   logic             out_last, out_valid;
   logic             out_ready = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int stalls = 0;
   int acc_cyc [72];
   logic [143:0] q_win [$];
   int q_row [$];
   int q_col [$];
   int q_last [$];
   int q_cyc [$];
   logic         stall_rdy [5];
   logic [143:0] stall_win [5];
   int           stall_row [5];
   int           stall_col [5];

   im2col_window_gen #(.IP_DATA_WIDTH(8), .FILTER_SIZE(3), .OFMAP_SIZE(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .out_window(out_window), .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // record every window transfer just before the edge that completes it
   always begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
         q_win.push_back(out_window);
         q_row.push_back(int'(out_row));
         q_col.push_back(int'(out_col));
         q_last.push_back(int'(out_last));
         q_cyc.push_back(cyc);
      end
   end

   function automatic logic [143:0] exp_win(input int oy, input int ox, input int base);
      logic [143:0] e;
      for (int k = 0; k < 9; k++) e[k*16 +: 16] = 16'((oy + k / 3) * 6 + ox + k % 3 + base);
      return e;
   endfunction

   task automatic clear_q;
      q_win.delete();
      q_row.delete();
      q_col.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic drive(input int npix, input int vpct, input int rpct, input int stall_en);
      int p = 0;
      int guard = 0;
      while (p < npix && guard < 4000) begin
         @(negedge clk);
         in_valid = $urandom_range(99) < vpct;
         in_pixel = 8'(p % 36 + 100 * (p / 36));
         out_ready = $urandom_range(99) < rpct;
         if (stall_en != 0 && stalls == 0 && out_valid && out_row == 2'd1 && out_col == 2'd2) begin
            in_valid = 1'b1;
            for (int s = 0; s < 5; s++) begin
               out_ready = 1'b0;
               #1;
               stall_rdy[s] = in_ready;
               stall_win[s] = out_window;
               stall_row[s] = int'(out_row);
               stall_col[s] = int'(out_col);
               @(negedge clk);
            end
            stalls = 1;
            out_ready = 1'b1;
         end
         #1;
         if (in_valid && in_ready) begin
            acc_cyc[p] = cyc;
            p++;
         end
         guard++;
      end
   endtask

   task automatic drain;
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
      total++; if (out_row !== 2'd0) begin bad++; $display("FAIL reset_row got=%0d exp=0", out_row); end
      total++; if (out_col !== 2'd0) begin bad++; $display("FAIL reset_col got=%0d exp=0", out_col); end
      total++; if (out_window !== 144'd0) begin bad++; $display("FAIL reset_window got=%h exp=0", out_window); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stream;
      int n;
      clear_q();
      drive(36, 100, 100, 0);
      drain();
      total++; if (q_win.size() != 16) begin bad++; $display("FAIL stream_count got=%0d exp=16", q_win.size()); end
      n = q_win.size() < 16 ? q_win.size() : 16;
      for (int i = 0; i < n; i++) begin
         int oy = i / 4;
         int ox = i % 4;
         int p = (oy + 2) * 6 + ox + 2;
         total++; if (q_win[i] !== exp_win(oy, ox, 0)) begin bad++; $display("FAIL stream_win[%0d] got=%h exp=%h", i, q_win[i], exp_win(oy, ox, 0)); end
         total++; if (q_row[i] * 100 + q_col[i] * 10 + q_last[i] != oy * 100 + ox * 10 + int'(i == 15)) begin bad++; $display("FAIL stream_pos[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, q_row[i], q_col[i], q_last[i], oy, ox, int'(i == 15)); end
         total++; if (q_cyc[i] != acc_cyc[p] + 1) begin bad++; $display("FAIL stream_latency[%0d] got=%0d exp=%0d", i, q_cyc[i], acc_cyc[p] + 1); end
      end
   endtask

   task automatic test_stall;
      int n;
      clear_q();
      stalls = 0;
      drive(36, 100, 100, 1);
      drain();
      total++; if (stalls != 1) begin bad++; $display("FAIL stall_seen got=%0d exp=1", stalls); end
      for (int s = 0; s < 5; s++) begin
         total++; if (stall_rdy[s] !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", s, stall_rdy[s]); end
         total++; if (stall_win[s] !== exp_win(1, 2, 0)) begin bad++; $display("FAIL stall_win[%0d] got=%h exp=%h", s, stall_win[s], exp_win(1, 2, 0)); end
         total++; if (stall_row[s] * 10 + stall_col[s] != 12) begin bad++; $display("FAIL stall_pos[%0d] got=%0d/%0d exp=1/2", s, stall_row[s], stall_col[s]); end
      end
      total++; if (q_win.size() != 16) begin bad++; $display("FAIL stall_count got=%0d exp=16", q_win.size()); end
      n = q_win.size() < 16 ? q_win.size() : 16;
      for (int i = 0; i < n; i++) begin
         total++; if (q_win[i] !== exp_win(i / 4, i % 4, 0)) begin bad++; $display("FAIL stall_stream_win[%0d] got=%h exp=%h", i, q_win[i], exp_win(i / 4, i % 4, 0)); end
      end
   endtask

   task automatic test_back_to_back;
      int n;
      int lasts = 0;
      clear_q();
      drive(72, 100, 100, 0);
      drain();
      total++; if (q_win.size() != 32) begin bad++; $display("FAIL b2b_count got=%0d exp=32", q_win.size()); end
      n = q_win.size() < 32 ? q_win.size() : 32;
      for (int i = 0; i < n; i++) begin
         int f = i / 16;
         int j = i % 16;
         int p = 36 * f + (j / 4 + 2) * 6 + j % 4 + 2;
         lasts += q_last[i];
         total++; if (q_win[i] !== exp_win(j / 4, j % 4, 100 * f)) begin bad++; $display("FAIL b2b_win[%0d] got=%h exp=%h", i, q_win[i], exp_win(j / 4, j % 4, 100 * f)); end
         total++; if (q_row[i] * 100 + q_col[i] * 10 + q_last[i] != (j / 4) * 100 + (j % 4) * 10 + int'(j == 15)) begin bad++; $display("FAIL b2b_pos[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, q_row[i], q_col[i], q_last[i], j / 4, j % 4, int'(j == 15)); end
         total++; if (q_cyc[i] != acc_cyc[p] + 1) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, q_cyc[i], acc_cyc[p] + 1); end
      end
      total++; if (lasts != 2) begin bad++; $display("FAIL b2b_last_count got=%0d exp=2", lasts); end
   endtask

   task automatic test_random;
      int n;
      clear_q();
      drive(36, 60, 50, 0);
      drain();
      total++; if (q_win.size() != 16) begin bad++; $display("FAIL rand_count got=%0d exp=16", q_win.size()); end
      n = q_win.size() < 16 ? q_win.size() : 16;
      for (int i = 0; i < n; i++) begin
         total++; if (q_win[i] !== exp_win(i / 4, i % 4, 0)) begin bad++; $display("FAIL rand_win[%0d] got=%h exp=%h", i, q_win[i], exp_win(i / 4, i % 4, 0)); end
         total++; if (q_row[i] * 100 + q_col[i] * 10 + q_last[i] != (i / 4) * 100 + (i % 4) * 10 + int'(i == 15)) begin bad++; $display("FAIL rand_pos[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, q_row[i], q_col[i], q_last[i], i / 4, i % 4, int'(i == 15)); end
      end
   endtask

   task automatic test_reset_mid;
      int n;
      clear_q();
      drive(21, 100, 100, 0);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      total++; if (out_valid !== 1'b1 || out_row !== 2'd1 || out_col !== 2'd0) begin bad++; $display("FAIL midrst_pre got=%b/%0d/%0d exp=1/1/0", out_valid, out_row, out_col); end
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      total++; if (out_window !== 144'd0) begin bad++; $display("FAIL midrst_window got=%h exp=0", out_window); end
      total++; if (out_row !== 2'd0 || out_col !== 2'd0 || out_last !== 1'b0) begin bad++; $display("FAIL midrst_pos got=%0d/%0d/%b exp=0/0/0", out_row, out_col, out_last); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_q();
      drive(36, 100, 100, 0);
      drain();
      total++; if (q_win.size() != 16) begin bad++; $display("FAIL midrst_count got=%0d exp=16", q_win.size()); end
      n = q_win.size() < 16 ? q_win.size() : 16;
      for (int i = 0; i < n; i++) begin
         int p = (i / 4 + 2) * 6 + i % 4 + 2;
         total++; if (q_win[i] !== exp_win(i / 4, i % 4, 0)) begin bad++; $display("FAIL midrst_win[%0d] got=%h exp=%h", i, q_win[i], exp_win(i / 4, i % 4, 0)); end
         total++; if (q_row[i] * 100 + q_col[i] * 10 + q_last[i] != (i / 4) * 100 + (i % 4) * 10 + int'(i == 15)) begin bad++; $display("FAIL midrst_pos[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, q_row[i], q_col[i], q_last[i], i / 4, i % 4, int'(i == 15)); end
         total++; if (q_cyc[i] != acc_cyc[p] + 1) begin bad++; $display("FAIL midrst_latency[%0d] got=%0d exp=%0d", i, q_cyc[i], acc_cyc[p] + 1); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
